// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter owning a registered 4-to-1 W-bit mux with bounded hold time
module mux4_rr_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x0,
  output logic [3:0]   gnt,
  output logic         b1,
  output logic         b0,
  output logic [W-1:0] z,
  output logic         z_valid,
  output logic         busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_LAST = MAX_HOLD == 0 ? 8'd0 : 8'(MAX_HOLD - 1);
  logic [0:0]   state;
  logic [1:0]   ptr, o, scan, win;
  logic [7:0]   hold_cnt;
  logic [W-1:0] sel;
  logic         others, owner_req, release_o, rotate, new_grant;
  assign o         = {b1, b0};
  assign busy      = |gnt;
  assign sel       = o[1] ? (o[0] ? x3 : x2) : (o[0] ? x1 : x0);
  assign owner_req = state == GRANT && req[o];
  assign others    = |(req & ~(4'b0001 << o));
  assign release_o = state == GRANT && !req[o];
  assign rotate    = MAX_HOLD != 0 && owner_req && others && hold_cnt == HOLD_LAST;
  // A releasing or rotated owner is scanned last so the others get their turn first
  assign scan      = (release_o || rotate) ? o + 2'd1 : ptr;
  assign new_grant = state == IDLE ? |req : (release_o ? others : rotate);
  always_comb begin
    win = scan + 2'd3;
    for (int k = 2; k >= 0; k--)
      if (req[scan + 2'(k)]) win = scan + 2'(k);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      {b1, b0} <= 2'b00;
      z        <= '0;
      z_valid  <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
    end else begin
      z_valid <= owner_req;
      if (owner_req) z <= sel;
      if (release_o || rotate) ptr <= o + 2'd1;
      if (new_grant) begin
        state    <= GRANT;
        gnt      <= 4'b0001 << win;
        {b1, b0} <= win;
        hold_cnt <= 8'd0;
      end else if (release_o) begin
        state <= IDLE;
        gnt   <= 4'b0000;
      end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed checks of the round-robin mux arbiter at MAX_HOLD=16 and MAX_HOLD=4
module tb_mux4_rr_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] x3 = 8'h44, x2 = 8'h33, x1 = 8'h22, x0 = 8'h11;
  logic [3:0] g16, g4;
  logic       b1_16, b0_16, b1_4, b0_4, zv16, zv4, busy16, busy4;
  logic [7:0] z16, z4;
  int checks = 0;
  int failures = 0;

  mux4_rr_arbiter #(.W(8), .MAX_HOLD(16)) dut16 (
    .clock(clock), .reset(reset), .req(req), .x3(x3), .x2(x2), .x1(x1), .x0(x0),
    .gnt(g16), .b1(b1_16), .b0(b0_16), .z(z16), .z_valid(zv16), .busy(busy16));
  mux4_rr_arbiter #(.W(8), .MAX_HOLD(4)) dut4 (
    .clock(clock), .reset(reset), .req(req), .x3(x3), .x2(x2), .x1(x1), .x0(x0),
    .gnt(g4), .b1(b1_4), .b0(b0_4), .z(z4), .z_valid(zv4), .busy(busy4));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [3:0] g, input logic [1:0] b,
                          input logic [7:0] zz, input logic zv);
    chk({tag, " gnt16"}, 32'(g16), 32'(g));
    chk({tag, " sel16"}, 32'({b1_16, b0_16}), 32'(b));
    chk({tag, " z16"}, 32'(z16), 32'(zz));
    chk({tag, " zv16"}, 32'(zv16), 32'(zv));
    chk({tag, " busy16"}, 32'(busy16), 32'(|g));
    chk({tag, " gnt4"}, 32'(g4), 32'(g));
    chk({tag, " z4"}, 32'(z4), 32'(zz));
    chk({tag, " zv4"}, 32'(zv4), 32'(zv));
  endtask

  initial begin
    req = 4'b1111;
    step();
    chk_both("reset", 4'b0000, 2'b00, 8'h00, 1'b0);
    reset = 1'b0;
    step();
    chk_both("first_grant", 4'b0001, 2'b00, 8'h00, 1'b0);
    step();
    chk_both("first_data", 4'b0001, 2'b00, 8'h11, 1'b1);
    req = 4'b0100;
    x2 = 8'hA5;
    step();
    chk_both("single_grant", 4'b0100, 2'b10, 8'h11, 1'b0);
    step();
    chk_both("single_data", 4'b0100, 2'b10, 8'hA5, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("hold gnt16", 32'(g16), 32'(4'b0100));
      chk("hold gnt4", 32'(g4), 32'(4'b0100));
    end
    req = 4'b0000;
    step();
    chk_both("drop", 4'b0000, 2'b10, 8'hA5, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    step();
    chk_both("rr0", 4'b0001, 2'b00, 8'h00, 1'b0);
    req = 4'b1110;
    step();
    chk_both("rr1", 4'b0010, 2'b01, 8'h00, 1'b0);
    req = 4'b1101;
    step();
    chk_both("rr2", 4'b0100, 2'b10, 8'h00, 1'b0);
    req = 4'b1011;
    step();
    chk_both("rr3", 4'b1000, 2'b11, 8'h00, 1'b0);
    req = 4'b0111;
    step();
    chk_both("rr4", 4'b0001, 2'b00, 8'h00, 1'b0);
    reset = 1'b1;
    req = 4'b0011;
    step();
    reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      step();
      chk("rot gnt4", 32'(g4), 32'(((i / 4) % 2) != 0 ? 4'b0010 : 4'b0001));
      chk("rot gnt16", 32'(g16), 32'(i < 16 ? 4'b0001 : 4'b0010));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1000;
    step();
    chk_both("own3_grant", 4'b1000, 2'b11, 8'h00, 1'b0);
    step();
    chk_both("own3_data", 4'b1000, 2'b11, 8'h44, 1'b1);
    req = 4'b0110;
    x1 = 8'h77;
    step();
    chk("handoff gnt16", 32'(g16), 32'(4'b0010));
    chk("handoff gnt4", 32'(g4), 32'(4'b0010));
    chk("handoff busy16", 32'(busy16), 32'(1'b1));
    step();
    chk_both("handoff_data", 4'b0010, 2'b01, 8'h77, 1'b1);
    req = 4'b0100;
    step();
    step();
    chk_both("own2_data", 4'b0100, 2'b10, 8'hA5, 1'b1);
    reset = 1'b1;
    step();
    chk_both("mid_reset", 4'b0000, 2'b00, 8'h00, 1'b0);
    reset = 1'b0;
    req = 4'b0110;
    step();
    chk_both("post_reset", 4'b0010, 2'b01, 8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
